// File: rtl/sdram_rd_burst.sv
// rtl/sdram_rd_burst.sv - SDRAM read-burst engine: ACT/READ/PRE sequencing with grant yield and page carry.
module sdram_rd_burst #(
    parameter int DW     = 16,
    parameter int ROW_W  = 12,
    parameter int COL_W  = 9,
    parameter int BANK_W = 2,
    parameter int LEN_W  = 8,
    parameter int BURST  = 4,
    parameter int CASL   = 3,
    parameter int TRCD   = 2,
    parameter int TRP    = 2
) (
    input  logic                           sclk,
    input  logic                           srst_n,
    input  logic                           rd_trig,
    input  logic [LEN_W-1:0]               rd_len,
    input  logic [BANK_W+ROW_W+COL_W-1:0]  rd_addr,
    input  logic                           rd_en,
    output logic                           flag_rd_ask,
    output logic                           flag_rd_end,
    output logic                           rd_busy,
    output logic [DW-1:0]                  rd_data,
    output logic                           rd_data_en,
    output logic [3:0]                     sdram_cmd,
    output logic [ROW_W-1:0]               sdram_addr,
    output logic [BANK_W-1:0]              sdram_bank,
    input  logic [DW-1:0]                  sdram_data
);
    localparam int AW    = BANK_W + ROW_W + COL_W;
    localparam int CMAX  = (BURST > TRCD) ? ((BURST > TRP) ? BURST : TRP)
                                          : ((TRCD > TRP) ? TRCD : TRP);
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam int WIN_W = $clog2(BURST + 1);

    localparam logic [3:0]       CMD_NOP    = 4'b0111;
    localparam logic [3:0]       CMD_ACT    = 4'b0011;
    localparam logic [3:0]       CMD_RD     = 4'b0101;
    localparam logic [3:0]       CMD_PRE    = 4'b0010;
    localparam logic [AW-1:0]    BURST_A    = AW'(BURST);
    localparam logic [WIN_W-1:0] BURST_W    = WIN_W'(BURST);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);
    localparam logic [CNT_W-1:0] TRCD_LAST  = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] TRP_LAST   = CNT_W'(TRP - 1);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_ASK  = 5'b00010,
        S_ACT  = 5'b00100,
        S_RD   = 5'b01000,
        S_PRE  = 5'b10000
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              page_q, page_d;
    logic              busy_q, busy_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ROW_W-1:0]  sa_q, sa_d;
    logic [BANK_W-1:0] sb_q, sb_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [CASL:0]     en_sh_q;
    logic [DW-1:0]     data_q;

    logic [AW-1:0]     addr_nx;
    logic [ROW_W-1:0]  rd_a;
    logic [ROW_W-1:0]  pre_a;

    assign addr_nx = addr_q + BURST_A;

    // READ carries the column with A10 low (no auto-precharge); PRE uses A10 high (all banks).
    always_comb begin
        rd_a              = '0;
        rd_a[COL_W-1:0]   = addr_q[COL_W-1:0];
        rd_a[10]          = 1'b0;
        pre_a             = '0;
        pre_a[10]         = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        page_d      = page_q;
        busy_d      = busy_q;
        cmd_d       = CMD_NOP;
        sa_d        = sa_q;
        sb_d        = sb_q;
        win_d       = (win_q != '0) ? win_q - 1'b1 : '0;
        flag_rd_ask = (state_q == S_ASK);
        flag_rd_end = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rd_trig && rd_len != '0) begin
                    addr_d  = rd_addr;
                    rem_d   = rd_len;
                    busy_d  = 1'b1;
                    state_d = S_ASK;
                end
            end
            S_ASK: begin
                if (rd_en) begin
                    state_d = S_ACT;
                    cnt_d   = '0;
                end
            end
            S_ACT: begin
                if (cnt_q == '0) begin
                    cmd_d  = CMD_ACT;
                    sa_d   = addr_q[COL_W +: ROW_W];
                    sb_d   = addr_q[AW-1 -: BANK_W];
                    page_d = 1'b0;
                end
                if (cnt_q == TRCD_LAST) begin
                    state_d = S_RD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD: begin
                cnt_d = (cnt_q == BURST_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == '0) begin
                    // page_q means the previous READ wrapped the column: the open row is finished.
                    if (rem_q == '0 || page_q || !rd_en) begin
                        cmd_d   = CMD_PRE;
                        sa_d    = pre_a;
                        state_d = S_PRE;
                        cnt_d   = '0;
                    end else begin
                        cmd_d  = CMD_RD;
                        sa_d   = rd_a;
                        sb_d   = addr_q[AW-1 -: BANK_W];
                        rem_d  = rem_q - 1'b1;
                        addr_d = addr_nx;
                        page_d = (addr_nx[COL_W-1:0] == '0);
                        win_d  = BURST_W;
                    end
                end
            end
            S_PRE: begin
                if (cnt_q == TRP_LAST) begin
                    cnt_d = '0;
                    if (rem_q == '0) begin
                        flag_rd_end = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end else if (rd_en) begin
                        state_d = S_ACT;
                    end else begin
                        flag_rd_end = 1'b1;
                        state_d     = S_ASK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            page_q  <= 1'b0;
            busy_q  <= 1'b0;
            cmd_q   <= CMD_NOP;
            sa_q    <= '0;
            sb_q    <= '0;
            win_q   <= '0;
            en_sh_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            page_q  <= page_d;
            busy_q  <= busy_d;
            cmd_q   <= cmd_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            win_q   <= win_d;
            // Valid window is delayed by CAS latency plus the input register stage.
            en_sh_q <= {en_sh_q[CASL-1:0], (win_q != '0)};
            data_q  <= sdram_data;
        end
    end

    assign rd_busy    = busy_q;
    assign rd_data    = data_q;
    assign rd_data_en = en_sh_q[CASL];
    assign sdram_cmd  = cmd_q;
    assign sdram_addr = sa_q;
    assign sdram_bank = sb_q;

endmodule

// File: doc/sdram_rd_burst.md
# sdram_rd_burst

Parametrised SDRAM read-burst engine. It converts one read request (start address plus length in bursts) into ACTIVE / READ / PRECHARGE command sequences and returns the read data with a valid strobe. It sits behind the SDRAM arbiter as a peer of the write and refresh engines. Relative to the fixed 16-bit single-bank reader, it adds:
- configurable data, row, column and bank widths
- configurable burst length and CAS latency
- tRCD and tRP wait counters
- row-to-bank carry on page crossing
- grant-yield and resume mid-transfer

## Interface
- DW, 16: data width.
- ROW_W, 12: row address width (must be ≥ 11).
- COL_W, 9: column address width.
- BANK_W, 2: bank address width.
- LEN_W, 8: width of rd_len.
- BURST, 4: SDRAM burst length (power of 2, less than 2^COL_W).
- CASL, 3: CAS latency in cycles.
- TRCD, 2: ACTIVE-to-READ cycles (≥ 1).
- TRP, 2: PRECHARGE-to-next-command cycles (≥ 1).

Ports:
- sclk  in  1  clock; all logic is on the rising edge.
- srst_n  in  1  reset, asynchronous, active-low.
- rd_trig  in  1  start pulse; sampled only in IDLE.
- rd_len  in  LEN_W  number of bursts; 0 means no operation.
- rd_addr  in  BANK_W+ROW_W+COL_W  start address as {bank,row,col}; col must be BURST-aligned.
- rd_en  in  1  arbiter grant.
- flag_rd_ask  out  1  grant request.
- flag_rd_end  out  1  one-cycle pulse that releases the grant.
- rd_busy  out  1  high from the accepted rd_trig until the final flag_rd_end.
- rd_data  out  DW  registered copy of sdram_data.
- rd_data_en  out  1  rd_data valid.
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}: NOP 0111, ACT 0011, READ 0101, PRE 0010.
- sdram_addr  out  ROW_W  SDRAM address bus.
- sdram_bank  out  BANK_W  bank select.
- sdram_data  in  DW  SDRAM data bus.

## Operation
- One-hot states: IDLE, ASK, ACT, RD, PRE.
- IDLE:
  - On rd_trig with rd_len≠0: latch bank, row, col and rem=rd_len; set rd_busy; go to ASK.
  - rd_trig with rd_len=0 is ignored. rd_trig outside IDLE is ignored.
- ASK: flag_rd_ask=1 (combinational on state). Go to ACT on rd_en=1, otherwise hold.
- ACT: issue ACT with sdram_addr=row and sdram_bank=bank, then TRCD-1 NOPs, then go to RD.
- RD: issue READ (sdram_addr = col zero-extended, A10=0) every BURST cycles, NOP in between. At each READ:
  - rem -= 1.
  - {bank,row,col} += BURST, carrying col→row→bank; the bank field wraps to 0.
- Stop condition: READ issuing stops when any of the following holds at a READ slot:
  - rem=0,
  - the column carry occurred (page end), or
  - rd_en=0.
  After a stop, go to PRE at the slot where the next READ would have been.
- PRE: issue PRE with sdram_addr = 1 shifted left by 10 (all banks), then TRP-1 NOPs. In the last PRE cycle:
  - rem=0: flag_rd_end=1, clear rd_busy, go to IDLE.
  - rem≠0 and rd_en=1: go to ACT directly; grant is kept, no flag_rd_end.
  - rem≠0 and rd_en=0: flag_rd_end=1, go to ASK; resume at the latched next address.
- Data path:
  - rd_data <= sdram_data every cycle.
  - rd_data_en comes from a CASL+1-deep shift of a per-READ BURST-cycle window. It is independent of state, so in-flight data drains after PRE.
- Reset values: state IDLE; sdram_cmd NOP; sdram_addr 0; sdram_bank 0; rd_data 0; rd_data_en 0; rd_busy 0; flag_rd_ask 0; flag_rd_end 0; all counters 0.
- Reset mid-operation aborts immediately. In-flight data is dropped and rd_data_en goes to 0 without completion.

## Timing
- sdram_cmd, sdram_addr and sdram_bank are registered: the command for a state cycle appears one cycle later.
- With the state entering ACT at cycle T0:
  - ACT is visible at T1.
  - The first READ is visible at T1+TRCD.
  - READs follow every BURST cycles, gapless.
- For a READ visible at cycle R:
  - rd_data_en is high for cycles R+CASL+1 through R+CASL+BURST.
  - rd_data carries words col..col+BURST-1 in order.
- Last READ at R: PRE is visible at R+BURST; flag_rd_end pulses at R+BURST+TRP-1.
- Minimum PRE-to-ACT spacing is TRP+1 cycles.
- The flag_rd_ask to rd_en response has no fixed latency. rd_en may drop at any cycle; it is acted on only at READ slots and in the last PRE cycle.

## Test plan
- Single burst, defaults, rd_len=1, rd_addr={2'd1,12'h005,9'h010}, rd_en tied high:
  - ACT with row 005, bank 1.
  - READ col 010 two cycles later.
  - rd_data_en high for 4 cycles, starting 4 cycles after the READ.
  - PRE 4 cycles after the READ.
  - flag_rd_end 1 cycle after PRE; back to IDLE.
- Back-to-back, rd_len=3, col 000: READs at cols 000/004/008 spaced 4 cycles; rd_data_en continuous for 12 cycles; one ACT and one PRE.
- Page cross, rd_len=2, {0,12'h003,9'h1FC}:
  - READ col 1FC, PRE, ACT row 004, READ col 000.
  - No flag_rd_end between the two READs.
- Bank carry, rd_len=2, {0,12'hFFF,9'h1FC}: second ACT goes to bank 1, row 000.
- Yield, rd_len=8, rd_en dropped after the 2nd READ:
  - PRE, then flag_rd_end, then ASK.
  - After regrant: ACT on the same row, READ col 008 or later; 8 READs total.
- Reset mid-burst (srst_n low 1 cycle, 2 cycles after a READ): all outputs return to reset values immediately; a new rd_trig runs normally.
